// File: rtl/seg7_reader.sv
// Seven-segment bus reader: synchronizes a segment bus, qualifies each pattern by
// stability, decodes it against the hex glyph table and presents the digit on valid/ready.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clear,
  input  logic             out_ready,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             err_pulse,
  output logic             pattern_err,
  output logic             overrun,
  output logic [CNT_W-1:0] digit_count
);

  localparam logic [3:0] STB_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic       known;
    logic       blank;
    logic [3:0] value;
  } glyph_t;

  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic [6:0]       r_prev;
  logic [3:0]       r_cnt;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_changed;
  logic             w_accept;
  glyph_t           w_glyph;
  logic             w_emit;
  logic             w_bad;
  logic             w_xfer;
  logic [3:0]       r_digit;
  logic             r_digit_valid;
  logic             r_err_pulse;
  logic             r_pattern_err;
  logic             r_overrun;
  logic [CNT_W-1:0] r_digit_count;

  // seg_in is asynchronous; only the second stage is observed by the rest of the logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_changed = (r_sync2 != r_prev);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_changed) begin
      r_cnt <= '0;
    end else if (r_cnt != STB_MAX) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE:   if (w_changed) w_state_next = SETTLE;
      SETTLE: if (!w_changed && r_cnt == STB_MAX) begin
        w_accept     = 1'b1;
        w_state_next = LOCKED;
      end
      LOCKED: if (w_changed) w_state_next = SETTLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Glyph table, bit order gfedcba.
  always_comb begin
    w_glyph = '{known: 1'b1, blank: 1'b0, value: 4'h0};
    unique case (r_sync2)
      7'h3F: w_glyph.value = 4'h0;
      7'h06: w_glyph.value = 4'h1;
      7'h5B: w_glyph.value = 4'h2;
      7'h4F: w_glyph.value = 4'h3;
      7'h66: w_glyph.value = 4'h4;
      7'h6D: w_glyph.value = 4'h5;
      7'h7D: w_glyph.value = 4'h6;
      7'h07: w_glyph.value = 4'h7;
      7'h7F: w_glyph.value = 4'h8;
      7'h6F: w_glyph.value = 4'h9;
      7'h77: w_glyph.value = 4'hA;
      7'h7C: w_glyph.value = 4'hB;
      7'h39: w_glyph.value = 4'hC;
      7'h5E: w_glyph.value = 4'hD;
      7'h79: w_glyph.value = 4'hE;
      7'h71: w_glyph.value = 4'hF;
      7'h00: w_glyph.blank = 1'b1;
      default: w_glyph.known = 1'b0;
    endcase
  end

  assign w_emit = w_accept && w_glyph.known && !w_glyph.blank;
  assign w_bad  = w_accept && !w_glyph.known;
  assign w_xfer = r_digit_valid && out_ready;

  // One-entry output register: a new digit may replace the held one only when it transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
    end else if (w_emit && (!r_digit_valid || out_ready)) begin
      r_digit       <= w_glyph.value;
      r_digit_valid <= 1'b1;
    end else if (w_xfer) begin
      r_digit_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_pulse   <= 1'b0;
      r_pattern_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_digit_count <= '0;
    end else begin
      r_err_pulse <= w_bad;
      if (clear) begin
        r_pattern_err <= 1'b0;
        r_overrun     <= 1'b0;
        r_digit_count <= '0;
      end else begin
        r_pattern_err <= r_pattern_err | w_bad;
        r_overrun     <= r_overrun | (w_emit && r_digit_valid && !out_ready);
        r_digit_count <= r_digit_count + {{(CNT_W-1){1'b0}}, w_xfer};
      end
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign err_pulse   = r_err_pulse;
  assign pattern_err = r_pattern_err;
  assign overrun     = r_overrun;
  assign digit_count = r_digit_count;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: expected digits go into a scoreboard queue and a
// negedge monitor pops and compares each transfer the DUT makes.
module tb_seg7_reader;

  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic [6:0]       seg_in;
  logic             clear;
  logic             out_ready;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             err_pulse;
  logic             pattern_err;
  logic             overrun;
  logic [CNT_W-1:0] digit_count;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_reader #(.STABLE_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .clear       (clear),
    .out_ready   (out_ready),
    .digit       (digit),
    .digit_valid (digit_valid),
    .err_pulse   (err_pulse),
    .pattern_err (pattern_err),
    .overrun     (overrun),
    .digit_count (digit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Leaves the caller 1 time unit after the n-th rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && digit_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_digit: got %0h expected none at %0t", digit, $time);
      end else begin
        check("sb_digit", {28'd0, digit}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int pulses;
    reset     = 1'b1;
    seg_in    = 7'h00;
    clear     = 1'b0;
    out_ready = 1'b1;
    step(3);
    check("rst_valid", {31'd0, digit_valid}, 0);
    check("rst_digit", {28'd0, digit}, 0);
    check("rst_err", {29'd0, err_pulse, pattern_err, overrun}, 0);
    check("rst_count", {24'd0, digit_count}, 0);
    reset = 1'b0;

    // 4F held: valid exactly after edge 6, single transfer, no re-emission.
    seg_in = 7'h4F;
    exp_q.push_back(3);
    step(6);
    check("lat_not_early", {31'd0, digit_valid}, 0);
    step(1);
    check("lat_valid", {31'd0, digit_valid}, 1);
    check("lat_digit", {28'd0, digit}, 3);
    step(10);
    check("hold_count", {24'd0, digit_count}, 1);
    check("hold_valid", {31'd0, digit_valid}, 0);
    check("hold_q_empty", exp_q.size(), 0);

    // All sixteen glyphs in order, after a blank so 4F is seen again.
    seg_in = 7'h00;
    step(8);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seg_in = glyphs[i];
      exp_q.push_back(i);
      step(8);
    end
    step(4);
    check("all_count", {24'd0, digit_count}, 16);
    check("all_perr", {31'd0, pattern_err}, 0);
    check("all_q_empty", exp_q.size(), 0);

    // Short 7F, 2-cycle glitch to blank, then 7F held: exactly one 8.
    seg_in = 7'h00;
    step(8);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    seg_in = 7'h7F;
    step(2);
    seg_in = 7'h00;
    step(2);
    seg_in = 7'h7F;
    exp_q.push_back(8);
    step(12);
    check("glitch_count", {24'd0, digit_count}, 1);
    check("glitch_q_empty", exp_q.size(), 0);

    // Overrun: 06 held unread, 5B dropped.
    clear     = 1'b1;
    out_ready = 1'b0;
    step(1);
    clear  = 1'b0;
    seg_in = 7'h06;
    exp_q.push_back(1);
    step(8);
    seg_in = 7'h5B;
    step(8);
    check("ovr_valid", {31'd0, digit_valid}, 1);
    check("ovr_digit", {28'd0, digit}, 1);
    check("ovr_flag", {31'd0, overrun}, 1);
    out_ready = 1'b1;
    step(3);
    check("ovr_count", {24'd0, digit_count}, 1);
    check("ovr_drained", {31'd0, digit_valid}, 0);
    check("ovr_q_empty", exp_q.size(), 0);

    // Invalid pattern 55: one-cycle err_pulse, sticky pattern_err, then clear.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_overrun", {31'd0, overrun}, 0);
    seg_in = 7'h55;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (err_pulse) pulses++;
    end
    check("err_pulse_width", pulses, 1);
    check("err_sticky", {31'd0, pattern_err}, 1);
    check("err_no_valid", {31'd0, digit_valid}, 0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("err_cleared", {31'd0, pattern_err}, 0);

    // Reset while A is pending; A must come back after re-settling.
    out_ready = 1'b0;
    seg_in    = 7'h77;
    exp_q.push_back(10);
    step(8);
    check("pre_rst_digit", {28'd0, digit}, 10);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, digit_valid}, 0);
    check("async_rst_digit", {28'd0, digit}, 0);
    check("async_rst_count", {24'd0, digit_count}, 0);
    void'(exp_q.pop_back());
    step(2);
    reset     = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(10);
    step(6);
    check("rerun_not_early", {31'd0, digit_valid}, 0);
    step(1);
    check("rerun_valid", {31'd0, digit_valid}, 1);
    check("rerun_digit", {28'd0, digit}, 10);
    step(3);
    check("rerun_count", {24'd0, digit_count}, 1);

    // Clear coinciding with a transfer leaves the count at 0.
    out_ready = 1'b0;
    seg_in    = 7'h06;
    exp_q.push_back(1);
    step(8);
    check("cx_valid", {31'd0, digit_valid}, 1);
    clear     = 1'b1;
    out_ready = 1'b1;
    step(1);
    clear = 1'b0;
    check("cx_count", {24'd0, digit_count}, 0);
    check("cx_valid_gone", {31'd0, digit_valid}, 0);
    step(2);
    check("final_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive-side counterpart of the team's hex-to-seven-segment decoder: samples a 7-bit segment bus and recovers the hex digit (0-F) it displays.
- Synchronizes the bus, qualifies each pattern by stability, decodes it against the fixed glyph table, and presents the digit on a valid/ready output.
- Used on-chip as a loopback checker for the display path, and as a front-end for reading an external segment driver.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before acceptance (legal range 2..15).
- CNT_W, 8, width of the transferred-digit counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset; all state to reset values immediately.
- seg_in  in  7  segment bus, active-high; bit0=a, bit1=b, ..., bit6=g; asynchronous to clock.
- clear  in  1  synchronous; clears pattern_err, overrun and digit_count.
- out_ready  in  1  consumer ready; transfer occurs on digit_valid && out_ready.
- digit  out  4  decoded hex value; held while digit_valid is high.
- digit_valid  out  1  digit available.
- err_pulse  out  1  one-cycle pulse when an accepted pattern is not in the table.
- pattern_err  out  1  sticky copy of err_pulse.
- overrun  out  1  sticky; an accepted digit was dropped.
- digit_count  out  CNT_W  number of completed transfers, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 0; FSM in IDLE; stability counter 0.
- Synchronizer: 2 flops per bit; s = second-stage value. Internal logic uses s only.
- Glyph table (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Blank = 00. Every other code is invalid.
- Stability: register s_prev each cycle. If s != s_prev, counter <= 0. Otherwise counter increments, saturating at STABLE_CYCLES-1.
- FSM states:
  - IDLE: after reset. Moves to SETTLE on the first cycle with s != s_prev.
  - SETTLE: counting. When the counter reaches STABLE_CYCLES-1 with s == s_prev, the pattern is accepted and the FSM moves to LOCKED.
  - LOCKED: holds while s == s_prev. Any change of s returns to SETTLE with the counter at 0.
- Each stable occurrence of a pattern is accepted exactly once. The same digit is re-emitted only after the bus changes and settles again. A pattern that is non-blank out of reset counts as a change from 00.
- Action on accept:
  - Blank: no emission, no error.
  - Valid glyph: emit the digit.
  - Invalid: err_pulse high for 1 cycle, pattern_err set; no emission.
- Timing: if seg_in changes before the first edge that samples it (edge 0) and then holds, digit_valid is high after edge STABLE_CYCLES+2. Glitches shorter than STABLE_CYCLES cycles produce no output.
- Output register, one entry:
  - Accept with digit_valid=0: load digit, set digit_valid.
  - Accept with digit_valid=1 and out_ready=1 in the same cycle: the old digit transfers, the new digit loads, digit_valid stays 1.
  - Accept with digit_valid=1 and out_ready=0: the new digit is dropped, overrun set, the old digit is held unchanged.
  - Transfer with no accept: digit_valid cleared next edge.
  - digit_count increments on every transfer.
- clear: pattern_err, overrun and digit_count go to 0 next edge. It does not affect digit_valid, digit or the FSM.
- Simultaneous events:
  - clear and err_pulse in the same cycle: clear wins; pattern_err = 0.
  - clear and transfer in the same cycle: digit_count = 0.
- Reset mid-settle or mid-transfer: everything returns to reset values at once, and any pending digit is lost. After release, the current bus pattern must re-settle; a held non-blank pattern is then accepted once.
- out_ready is ignored while digit_valid = 0.

Test Plan:
- Reset, out_ready=1, seg_in=4F held for 10 cycles -> digit_valid high after edge 6 (STABLE_CYCLES=4), digit=3, a single transfer, digit_count=1, no re-emission while held.
- Step through all 16 glyphs with 8 cycles each, out_ready=1 -> digits 0..F in order, digit_count=16, pattern_err=0.
- seg_in=7F, 2-cycle glitch to 00, back to 7F held -> exactly one digit 8 is emitted after the final settle; the glitch emits nothing.
- out_ready=0, apply 06 then 5B, each settled -> digit stays 1, overrun=1. Then out_ready=1 -> 1 transfers, digit_count=1, 5B is never output.
- seg_in=55 (invalid) settled -> err_pulse for exactly 1 cycle, pattern_err=1, no digit_valid. Then clear -> pattern_err=0.
- Assert reset while digit_valid=1 with digit=A -> all outputs 0 immediately. Release with seg_in still 77 -> digit A emitted again after STABLE_CYCLES+2 edges.
